// File: rtl/id_stage.sv
// Decode stage of the five-stage MIPS pipeline: IF/ID register, 32x32 register file,
// control decode, immediate extension and load-use hazard detection.
// Optional feature: define WB_BYPASS_EN for a write-through register file.
module id_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcPlus4In,
  input  logic        flush,
  input  logic        idExMemRead,
  input  logic [4:0]  idExRt,
  input  logic        wbWrite,
  input  logic [4:0]  wbReg,
  input  logic [31:0] wbData,
  output logic        pcEscreve,
  output logic [31:0] pcPlus4Out,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] immExt,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [31:0] jumpTarget,
  output logic        regDst,
  output logic        aluSrc,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        regWrite,
  output logic        branch,
  output logic        jump,
  output logic [1:0]  aluOp,
  output logic        illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_J     = 6'h02;

  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] rf_q [0:31];
  logic [5:0]  opcode;
  logic        rt_used;
  logic        stall;
  logic [31:0] rf_rd1, rf_rd2;

  // Decoded controls before the bubble is applied
  logic       dec_reg_dst, dec_alu_src, dec_mem_read, dec_mem_write;
  logic       dec_mem_to_reg, dec_reg_write, dec_branch, dec_jump;
  logic [1:0] dec_alu_op;
  logic       dec_illegal;

  assign opcode     = instr_q[31:26];
  assign rs         = instr_q[25:21];
  assign rt         = instr_q[20:16];
  assign rd         = instr_q[15:11];
  assign immExt     = {{16{instr_q[15]}}, instr_q[15:0]};
  assign pcPlus4Out = pc4_q;
  assign jumpTarget = {pc4_q[31:28], instr_q[25:0], 2'b00};

  // rt is only a source operand for R-type, beq and sw
  assign rt_used   = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_SW);
  assign stall     = idExMemRead && (idExRt != 5'd0) &&
                     ((idExRt == rs) || ((idExRt == rt) && rt_used));
  assign pcEscreve = flush || !stall;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    if (flush) begin
      instr_d = 32'd0;
      pc4_d   = 32'd0;
    end else if (!stall) begin
      instr_d = instrIn;
      pc4_d   = pcPlus4In;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instr_q <= 32'd0;
      pc4_q   <= 32'd0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
    end
  end

  // Entry 0 is reset and never written, so it always reads as zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
    end else if (wbWrite && (wbReg != 5'd0)) begin
      rf_q[wbReg] <= wbData;
    end
  end

  assign rf_rd1 = (rs == 5'd0) ? 32'd0 : rf_q[rs];
  assign rf_rd2 = (rt == 5'd0) ? 32'd0 : rf_q[rt];

`ifdef WB_BYPASS_EN
  assign readData1 = (wbWrite && (wbReg != 5'd0) && (wbReg == rs)) ? wbData : rf_rd1;
  assign readData2 = (wbWrite && (wbReg != 5'd0) && (wbReg == rt)) ? wbData : rf_rd2;
`else
  assign readData1 = rf_rd1;
  assign readData2 = rf_rd2;
`endif

  always_comb begin
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_reg_write  = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_alu_op     = 2'b00;
    dec_illegal    = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        // The all-zero word is the pipeline NOP, not an R-type write to r0
        if (instr_q != 32'd0) begin
          dec_reg_dst   = 1'b1;
          dec_reg_write = 1'b1;
          dec_alu_op    = 2'b10;
        end
      end
      OP_LW: begin
        dec_alu_src    = 1'b1;
        dec_mem_read   = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_reg_write  = 1'b1;
      end
      OP_SW: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_branch = 1'b1;
        dec_alu_op = 2'b01;
      end
      OP_ADDI: begin
        dec_alu_src   = 1'b1;
        dec_reg_write = 1'b1;
      end
      OP_J: begin
        dec_jump = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  // A stall turns the word in decode into a bubble toward EX
  always_comb begin
    regDst   = dec_reg_dst    && !stall;
    aluSrc   = dec_alu_src    && !stall;
    memRead  = dec_mem_read   && !stall;
    memWrite = dec_mem_write  && !stall;
    memToReg = dec_mem_to_reg && !stall;
    regWrite = dec_reg_write  && !stall;
    branch   = dec_branch     && !stall;
    jump     = dec_jump       && !stall;
    aluOp    = stall ? 2'b00 : dec_alu_op;
    illegal  = dec_illegal;
  end

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode of each opcode, load-use stall,
// flush priority, register-file write/read and r0 behaviour.
module tb_id_stage;

  logic        clock;
  logic        reset;
  logic [31:0] instrIn;
  logic [31:0] pcPlus4In;
  logic        flush;
  logic        idExMemRead;
  logic [4:0]  idExRt;
  logic        wbWrite;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        pcEscreve;
  logic [31:0] pcPlus4Out;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic [31:0] immExt;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [31:0] jumpTarget;
  logic        regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, jump;
  logic [1:0]  aluOp;
  logic        illegal;

  int checks;
  int failures;

  // {regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, jump, aluOp}
  logic [9:0] ctrl;
  assign ctrl = {regDst, aluSrc, memRead, memWrite, memToReg, regWrite, branch, jump, aluOp};

  localparam logic [9:0] C_NOP  = 10'b0000000000;
  localparam logic [9:0] C_R    = 10'b1000010010;
  localparam logic [9:0] C_LW   = 10'b0110110000;
  localparam logic [9:0] C_SW   = 10'b0101000000;
  localparam logic [9:0] C_BEQ  = 10'b0000001001;
  localparam logic [9:0] C_ADDI = 10'b0100010000;
  localparam logic [9:0] C_J    = 10'b0000000100;

  id_stage dut (
    .clock(clock), .reset(reset), .instrIn(instrIn), .pcPlus4In(pcPlus4In),
    .flush(flush), .idExMemRead(idExMemRead), .idExRt(idExRt),
    .wbWrite(wbWrite), .wbReg(wbReg), .wbData(wbData),
    .pcEscreve(pcEscreve), .pcPlus4Out(pcPlus4Out),
    .readData1(readData1), .readData2(readData2), .immExt(immExt),
    .rs(rs), .rt(rt), .rd(rd), .jumpTarget(jumpTarget),
    .regDst(regDst), .aluSrc(aluSrc), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .regWrite(regWrite), .branch(branch), .jump(jump),
    .aluOp(aluOp), .illegal(illegal)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic test_reset();
    reset = 1'b1; instrIn = 32'h0; pcPlus4In = 32'h0; flush = 1'b0;
    idExMemRead = 1'b0; idExRt = 5'd0; wbWrite = 1'b0; wbReg = 5'd0; wbData = 32'h0;
    #13;
    checks++;
    if (ctrl !== C_NOP || pcEscreve !== 1'b1 || illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_hold: ctrl=%b pcEscreve=%b illegal=%b expected ctrl=%b pcEscreve=1 illegal=0",
               ctrl, pcEscreve, illegal, C_NOP);
    end
    @(negedge clock);
    reset = 1'b0;
    tick();
    #1;
    checks++;
    if (ctrl !== C_NOP || illegal !== 1'b0 || pcEscreve !== 1'b1 ||
        readData1 !== 32'h0 || readData2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_nop: ctrl=%b illegal=%b pcEscreve=%b rd1=%h rd2=%h expected all zero, pcEscreve=1",
               ctrl, illegal, pcEscreve, readData1, readData2);
    end
  endtask

  task automatic test_rtype();
    wbWrite = 1'b1; wbReg = 5'd9; wbData = 32'h0BADF00D;
    tick();
    wbReg = 5'd8; wbData = 32'h12345678;
    instrIn = 32'h01095020; pcPlus4In = 32'h00400008;
    tick();
    wbWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h12345678 || readData2 !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL rtype_read: rd1=%h rd2=%h expected 12345678 0badf00d", readData1, readData2);
    end
    checks++;
    if (ctrl !== C_R || illegal !== 1'b0) begin
      failures++;
      $display("FAIL rtype_ctrl: ctrl=%b illegal=%b expected %b 0", ctrl, illegal, C_R);
    end
    checks++;
    if (rs !== 5'd8 || rt !== 5'd9 || rd !== 5'd10 || pcPlus4Out !== 32'h00400008) begin
      failures++;
      $display("FAIL rtype_fields: rs=%0d rt=%0d rd=%0d pc4=%h expected 8 9 10 00400008",
               rs, rt, rd, pcPlus4Out);
    end
  endtask

  task automatic test_addi();
    instrIn = 32'h2008FFFC; pcPlus4In = 32'h0040000C;
    tick();
    #1;
    checks++;
    if (immExt !== 32'hFFFFFFFC || ctrl !== C_ADDI || readData1 !== 32'h0) begin
      failures++;
      $display("FAIL addi: imm=%h ctrl=%b rd1=%h expected fffffffc %b 00000000",
               immExt, ctrl, readData1, C_ADDI);
    end
    // addi does not read rt, and an EX load to r0 never hazards
    idExMemRead = 1'b1; idExRt = 5'd8;
    #1;
    checks++;
    if (pcEscreve !== 1'b1 || ctrl !== C_ADDI) begin
      failures++;
      $display("FAIL addi_rt_nohazard: pcEscreve=%b ctrl=%b expected 1 %b", pcEscreve, ctrl, C_ADDI);
    end
    idExRt = 5'd0;
    #1;
    checks++;
    if (pcEscreve !== 1'b1) begin
      failures++;
      $display("FAIL r0_nohazard: pcEscreve=%b expected 1", pcEscreve);
    end
    idExMemRead = 1'b0;
  endtask

  task automatic test_hazard();
    instrIn = 32'h01095020; pcPlus4In = 32'h00400010;
    tick();
    idExMemRead = 1'b1; idExRt = 5'd9;
    instrIn = 32'h2008FFFC; pcPlus4In = 32'h00400014;
    #1;
    checks++;
    if (pcEscreve !== 1'b0 || ctrl !== C_NOP) begin
      failures++;
      $display("FAIL stall_bubble: pcEscreve=%b ctrl=%b expected 0 %b", pcEscreve, ctrl, C_NOP);
    end
    tick();
    #1;
    checks++;
    if (rs !== 5'd8 || rt !== 5'd9 || immExt !== 32'h00005020 || pcPlus4Out !== 32'h00400010) begin
      failures++;
      $display("FAIL stall_hold: rs=%0d rt=%0d imm=%h pc4=%h expected 8 9 00005020 00400010",
               rs, rt, immExt, pcPlus4Out);
    end
    idExMemRead = 1'b0;
    #1;
    checks++;
    if (pcEscreve !== 1'b1 || ctrl !== C_R) begin
      failures++;
      $display("FAIL stall_release: pcEscreve=%b ctrl=%b expected 1 %b", pcEscreve, ctrl, C_R);
    end
    tick();
    #1;
    checks++;
    if (ctrl !== C_ADDI || pcPlus4Out !== 32'h00400014) begin
      failures++;
      $display("FAIL stall_resume: ctrl=%b pc4=%h expected %b 00400014", ctrl, pcPlus4Out, C_ADDI);
    end
    // rs match stalls regardless of opcode
    instrIn = 32'h8D090004; pcPlus4In = 32'h00400018;
    tick();
    idExMemRead = 1'b1; idExRt = 5'd8;
    #1;
    checks++;
    if (pcEscreve !== 1'b0 || ctrl !== C_NOP) begin
      failures++;
      $display("FAIL stall_rs_lw: pcEscreve=%b ctrl=%b expected 0 %b", pcEscreve, ctrl, C_NOP);
    end
    idExMemRead = 1'b0;
    #1;
    checks++;
    if (pcEscreve !== 1'b1 || ctrl !== C_LW) begin
      failures++;
      $display("FAIL lw_decode: pcEscreve=%b ctrl=%b expected 1 %b", pcEscreve, ctrl, C_LW);
    end
  endtask

  task automatic test_flush();
    instrIn = 32'h01095020; pcPlus4In = 32'h00400020;
    tick();
    idExMemRead = 1'b1; idExRt = 5'd9; flush = 1'b1;
    #1;
    checks++;
    if (pcEscreve !== 1'b1) begin
      failures++;
      $display("FAIL flush_pcwrite: pcEscreve=%b expected 1", pcEscreve);
    end
    tick();
    flush = 1'b0; idExMemRead = 1'b0;
    #1;
    checks++;
    if (rs !== 5'd0 || rt !== 5'd0 || immExt !== 32'h0 || pcPlus4Out !== 32'h0 || ctrl !== C_NOP) begin
      failures++;
      $display("FAIL flush_zero: rs=%0d rt=%0d imm=%h pc4=%h ctrl=%b expected all zero",
               rs, rt, immExt, pcPlus4Out, ctrl);
    end
  endtask

  task automatic test_opcodes();
    logic [31:0] words [0:4];
    logic [9:0]  exp_ctrl [0:4];
    logic        exp_ill [0:4];
    words[0] = 32'hAD090008; exp_ctrl[0] = C_SW;  exp_ill[0] = 1'b0;
    words[1] = 32'h1109FFFF; exp_ctrl[1] = C_BEQ; exp_ill[1] = 1'b0;
    words[2] = 32'h08000010; exp_ctrl[2] = C_J;   exp_ill[2] = 1'b0;
    words[3] = 32'hFC000000; exp_ctrl[3] = C_NOP; exp_ill[3] = 1'b1;
    words[4] = 32'h00000020; exp_ctrl[4] = C_R;   exp_ill[4] = 1'b0;
    pcPlus4In = 32'hA0000004;
    for (int i = 0; i < 5; i++) begin
      instrIn = words[i];
      tick();
      #1;
      checks++;
      if (ctrl !== exp_ctrl[i] || illegal !== exp_ill[i]) begin
        failures++;
        $display("FAIL opcode_%0d: ctrl=%b illegal=%b expected %b %b",
                 i, ctrl, illegal, exp_ctrl[i], exp_ill[i]);
      end
      if (i == 1) begin
        checks++;
        if (immExt !== 32'hFFFFFFFF) begin
          failures++;
          $display("FAIL beq_imm: imm=%h expected ffffffff", immExt);
        end
      end
      if (i == 2) begin
        checks++;
        if (jumpTarget !== 32'hA0000040) begin
          failures++;
          $display("FAIL jump_target: jt=%h expected a0000040", jumpTarget);
        end
      end
    end
  endtask

  task automatic test_regfile();
    // IF/ID holds 0x00000020 (rs=rt=0): writes to r0 stay invisible
    wbWrite = 1'b1; wbReg = 5'd0; wbData = 32'hFFFFFFFF;
    #1;
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      failures++;
      $display("FAIL r0_same_cycle: rd1=%h rd2=%h expected 0 0", readData1, readData2);
    end
    tick();
    wbWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0) begin
      failures++;
      $display("FAIL r0_after_write: rd1=%h rd2=%h expected 0 0", readData1, readData2);
    end
    instrIn = 32'h01095020;
    tick();
    wbWrite = 1'b1; wbReg = 5'd8; wbData = 32'hAAAA5555;
    #1;
    checks++;
`ifdef WB_BYPASS_EN
    if (readData1 !== 32'hAAAA5555) begin
      failures++;
      $display("FAIL wb_same_cycle: rd1=%h expected aaaa5555", readData1);
    end
`else
    if (readData1 !== 32'h12345678) begin
      failures++;
      $display("FAIL wb_same_cycle: rd1=%h expected 12345678", readData1);
    end
`endif
    tick();
    wbWrite = 1'b0;
    #1;
    checks++;
    if (readData1 !== 32'hAAAA5555 || readData2 !== 32'h0BADF00D) begin
      failures++;
      $display("FAIL wb_after_edge: rd1=%h rd2=%h expected aaaa5555 0badf00d", readData1, readData2);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    #1;
    checks++;
    if (rs !== 5'd0 || ctrl !== C_NOP || pcEscreve !== 1'b1 || pcPlus4Out !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid: rs=%0d ctrl=%b pcEscreve=%b pc4=%h expected 0 0 1 0",
               rs, ctrl, pcEscreve, pcPlus4Out);
    end
    @(negedge clock);
    reset = 1'b0;
    instrIn = 32'h01095020;
    tick();
    #1;
    checks++;
    if (readData1 !== 32'h0 || readData2 !== 32'h0 || ctrl !== C_R) begin
      failures++;
      $display("FAIL reset_clears_rf: rd1=%h rd2=%h ctrl=%b expected 0 0 %b",
               readData1, readData2, ctrl, C_R);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_rtype();
    test_addi();
    test_hazard();
    test_flush();
    test_opcodes();
    test_regfile();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
